sky130_sram_rmw_bridge: RTL and testbench

//  Upstream front-end for the 1RW 32-bit OpenRAM macro: accepts valid/ready word requests, drives macro port 0,

---
 rtl/sky130_sram_rmw_bridge_pkg.sv | 32 +++
 rtl/sky130_sram_rmw_bridge_if.sv | 32 +++
 rtl/sky130_sram_rmw_bridge_byte_merge.sv | 25 ++
 rtl/sky130_sram_rmw_bridge.sv | 164 ++++++++++++++++
 tb/tb_sky130_sram_rmw_bridge.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sky130_sram_rmw_bridge_pkg.sv
// Shared types, default widths and parity helpers for the SRAM RMW bridge.
package sky130_sram_rmw_bridge_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 9;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

  // Helpers take a wide vector; callers zero-extend, which leaves parity unchanged.
  localparam int unsigned MAX_DATA_WIDTH = 64;
  localparam int unsigned MAX_WORD_WIDTH = MAX_DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_CAP  = 3'd2,
    ST_RMW_RD  = 3'd3,
    ST_RMW_CAP = 3'd4,
    ST_WR      = 3'd5,
    ST_RSP     = 3'd6
  } state_e;

  // Even parity bit to store alongside data.
  function automatic logic even_par(input logic [MAX_DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

  // Check over data plus stored parity; an unknown reduction counts as an error.
  function automatic logic par_err(input logic [MAX_WORD_WIDTH-1:0] word);
    return ((^word) !== 1'b0);
  endfunction

endpackage

// File: rtl/sky130_sram_rmw_bridge_if.sv
// Upstream request/response handshake bundle for the SRAM RMW bridge.
interface sky130_sram_rmw_bridge_if
  import sky130_sram_rmw_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_WMASKS = DEF_NUM_WMASKS
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_perr;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_perr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_perr
  );

endinterface

// File: rtl/sky130_sram_rmw_bridge_byte_merge.sv
// Byte-lane merge for read-modify-write: masked lanes come from the new data.
module sky130_sram_rmw_bridge_byte_merge
  import sky130_sram_rmw_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic [NUM_WMASKS-1:0] wmask_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] merged_c_o
);

  localparam int unsigned LANE_W = DATA_WIDTH / NUM_WMASKS;

  always_comb begin
    merged_c_o = rdata_i;
    for (int i = 0; i < int'(NUM_WMASKS); i++) begin
      if (wmask_i[i]) begin
        merged_c_o[i*LANE_W +: LANE_W] = wdata_i[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/sky130_sram_rmw_bridge.sv
// Front-end for a 1RW OpenRAM macro: word requests, parity in the spare bit,
// partial writes turned into read-modify-write, one request outstanding.
module sky130_sram_rmw_bridge
  import sky130_sram_rmw_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic                  clk0,
  input  logic                  rst0,
  sky130_sram_rmw_bridge_if.slave bus,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic                  sram_spare_wen0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH:0]   sram_din0,
  input  logic [DATA_WIDTH:0]   sram_dout0
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_perr_q, rsp_perr_d;

  logic                  req_ready_c;
  logic                  accept_c;
  logic                  dout_perr_c;
  logic [DATA_WIDTH-1:0] merged_c;

  assign req_ready_c = (state_q == ST_IDLE) && !rst0;
  assign accept_c    = bus.req_valid && req_ready_c;
  assign dout_perr_c = par_err(MAX_WORD_WIDTH'(sram_dout0));

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_perr  = rsp_perr_q;

  sky130_sram_rmw_bridge_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WMASKS (NUM_WMASKS)
  ) u_merge (
    .wmask_i    (wmask_q),
    .wdata_i    (wdata_q),
    .rdata_i    (sram_dout0[DATA_WIDTH-1:0]),
    .merged_c_o (merged_c)
  );

  // State, command and response registers.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_perr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_perr_q  <= rsp_perr_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_perr_d  = rsp_perr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          addr_d      = bus.req_addr;
          wmask_d     = bus.req_wmask;
          wdata_d     = bus.req_wdata;
          // Write acks carry zero data and no error unless a macro read says otherwise.
          rsp_rdata_d = '0;
          rsp_perr_d  = 1'b0;
          if (!bus.req_we) begin
            state_d = ST_RD;
          end else if (&bus.req_wmask) begin
            state_d = ST_WR;
          end else if (bus.req_wmask == '0) begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RD:     state_d = ST_RD_CAP;
      ST_RMW_RD: state_d = ST_RMW_CAP;
      ST_RD_CAP: begin
        rsp_rdata_d = sram_dout0[DATA_WIDTH-1:0];
        rsp_perr_d  = dout_perr_c;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RMW_CAP: begin
        // Merged word replaces the command data; the write gets fresh parity regardless.
        wdata_d    = merged_c;
        rsp_perr_d = dout_perr_c;
        state_d    = ST_WR;
      end
      ST_WR: begin
        rsp_rdata_d = '0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Macro port decode; reset overrides chip select so nothing new is sampled.
  always_comb begin
    sram_csb0       = 1'b1;
    sram_web0       = 1'b1;
    sram_wmask0     = '0;
    sram_spare_wen0 = 1'b0;
    sram_addr0      = addr_q;
    sram_din0       = {even_par(MAX_DATA_WIDTH'(wdata_q)), wdata_q};
    if (!rst0) begin
      case (state_q)
        ST_RD, ST_RMW_RD: begin
          sram_csb0 = 1'b0;
        end
        ST_WR: begin
          sram_csb0       = 1'b0;
          sram_web0       = 1'b0;
          sram_wmask0     = '1;
          sram_spare_wen0 = 1'b1;
        end
        default: begin
          sram_csb0 = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sky130_sram_rmw_bridge.sv
// Directed plus randomized bench for the SRAM RMW bridge with a behavioural macro.
module tb_sky130_sram_rmw_bridge;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 4;

  logic clk0 = 1'b0;
  logic rst0;
  always #5 clk0 = ~clk0;

  sky130_sram_rmw_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) bus ();

  logic          sram_csb0, sram_web0, sram_spare_wen0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW:0]   sram_din0;
  logic [DW:0]   sram_dout0;

  sky130_sram_rmw_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
    .clk0            (clk0),
    .rst0            (rst0),
    .bus             (bus),
    .sram_csb0       (sram_csb0),
    .sram_web0       (sram_web0),
    .sram_wmask0     (sram_wmask0),
    .sram_spare_wen0 (sram_spare_wen0),
    .sram_addr0      (sram_addr0),
    .sram_din0       (sram_din0),
    .sram_dout0      (sram_dout0)
  );

  // Behavioural 1RW macro: samples controls at posedge, read data valid before the next edge.
  logic [DW:0]   mem [0:511];
  logic          mem_clr, flip_req;
  logic [AW-1:0] flip_addr;
  int            wr_cnt, rd_cnt, csb_low_cnt, csb_rst_viol;
  logic [DW:0]   last_din;

  always @(posedge clk0) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
      wr_cnt <= 0; rd_cnt <= 0; csb_low_cnt <= 0; csb_rst_viol <= 0;
      last_din <= '0;
    end else begin
      if (flip_req) mem[flip_addr][DW] <= ~mem[flip_addr][DW];
      if (rst0 && !sram_csb0) csb_rst_viol <= csb_rst_viol + 1;
      if (!sram_csb0) begin
        csb_low_cnt <= csb_low_cnt + 1;
        if (!sram_web0) begin
          for (int b = 0; b < 4; b++)
            if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
          if (sram_spare_wen0) mem[sram_addr0][DW] <= sram_din0[DW];
          wr_cnt   <= wr_cnt + 1;
          last_din <= sram_din0;
        end else begin
          sram_dout0 <= mem[sram_addr0];
          rd_cnt     <= rd_cnt + 1;
        end
      end
    end
  end

  // Reference model: stored word per address and whether its stored parity is corrupt.
  logic [DW-1:0] ref_data [0:511];
  logic          ref_bad  [0:511];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic backdoor_flip(input logic [AW-1:0] a);
    flip_addr = a;
    flip_req  = 1'b1;
    @(negedge clk0);
    flip_req  = 1'b0;
    ref_bad[a] = !ref_bad[a];
  endtask

  // One full request/response; called and returns just after a negedge.
  task automatic transact(input logic we, input logic [AW-1:0] addr, input logic [3:0] mask,
                          input logic [DW-1:0] data, input int stall, input string tag,
                          output logic [DW-1:0] got, output logic got_perr);
    logic [DW-1:0] merged, exp_rd;
    logic          exp_perr;
    int            exp_lat, exp_wr, lat, wr0, wait_n;
    merged = ref_data[addr];
    for (int b = 0; b < 4; b++) if (mask[b]) merged[b*8 +: 8] = data[b*8 +: 8];
    if (!we) begin
      exp_rd = ref_data[addr]; exp_perr = ref_bad[addr]; exp_lat = 2; exp_wr = 0;
    end else if (mask == 4'hF) begin
      exp_rd = '0; exp_perr = 1'b0; exp_lat = 1; exp_wr = 1;
    end else if (mask == 4'h0) begin
      exp_rd = '0; exp_perr = 1'b0; exp_lat = 0; exp_wr = 0;
    end else begin
      exp_rd = '0; exp_perr = ref_bad[addr]; exp_lat = 3; exp_wr = 1;
    end
    wr0 = wr_cnt;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wmask = mask;
    bus.req_wdata = data;
    wait_n = 0;
    while (bus.req_ready !== 1'b1 && wait_n < 20) begin
      @(negedge clk0);
      wait_n++;
    end
    chk({tag, ":req_ready"}, 64'(bus.req_ready), 64'd1);
    @(negedge clk0);
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk0);
      lat++;
    end
    chk({tag, ":latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ":rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
    chk({tag, ":perr"}, 64'(bus.rsp_perr), 64'(exp_perr));
    got      = bus.rsp_rdata;
    got_perr = bus.rsp_perr;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk0);
      chk({tag, ":stall_valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, ":stall_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
      chk({tag, ":stall_ready"}, 64'(bus.req_ready), 64'd0);
      chk({tag, ":stall_csb"}, 64'(sram_csb0), 64'd1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk0);
    bus.rsp_ready = 1'b0;
    chk({tag, ":rsp_done"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ":ready_after"}, 64'(bus.req_ready), 64'd1);
    chk({tag, ":writes"}, 64'(wr_cnt - wr0), 64'(exp_wr));
    if (exp_wr != 0) chk({tag, ":din"}, 64'(last_din), 64'({^merged, merged}));
    if (we) begin
      ref_data[addr] = merged;
      if (mask != 4'h0) ref_bad[addr] = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] got;
    logic          gp;
    int            wr0, rd0, c0;

    for (int i = 0; i < 512; i++) begin
      ref_data[i] = '0;
      ref_bad[i]  = 1'b0;
    end
    rst0 = 1'b1; mem_clr = 1'b1; flip_req = 1'b0; flip_addr = '0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wmask = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;

    // Reset held with a request pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk0);
      chk("rst_csb", 64'(sram_csb0), 64'd1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    end
    rst0 = 1'b0; mem_clr = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk0);
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
    chk("post_rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("post_rst_perr", 64'(bus.rsp_perr), 64'd0);

    // Full write then read.
    transact(1'b1, 9'h005, 4'hF, 32'hDEADBEEF, 0, "s2_wr", got, gp);
    chk("s2_din_const", 64'(last_din), 64'(33'h0_DEADBEEF));
    transact(1'b0, 9'h005, 4'h0, 32'h0, 0, "s2_rd", got, gp);
    chk("s2_rdata_const", 64'(got), 64'(32'hDEADBEEF));

    // Partial write becomes read-modify-write.
    transact(1'b1, 9'h005, 4'b0010, 32'h00005A00, 0, "s3_pw", got, gp);
    chk("s3_din_const", 64'(last_din), 64'(33'h0_DEAD5AEF));
    transact(1'b0, 9'h005, 4'h0, 32'h0, 0, "s3_rd", got, gp);
    chk("s3_rdata_const", 64'(got), 64'(32'hDEAD5AEF));

    // Corrupted stored parity reported on read, then repaired by an RMW.
    transact(1'b1, 9'h007, 4'hF, 32'h00000001, 0, "s4_wr", got, gp);
    chk("s4_din_const", 64'(last_din), 64'(33'h1_00000001));
    backdoor_flip(9'h007);
    transact(1'b0, 9'h007, 4'h0, 32'h0, 0, "s4_rd", got, gp);
    chk("s4_rdata_const", 64'(got), 64'(32'h00000001));
    chk("s4_perr_const", 64'(gp), 64'd1);
    transact(1'b1, 9'h007, 4'b0100, 32'h00AB0000, 0, "s4_rmw_bad", got, gp);
    chk("s4_rmw_perr_const", 64'(gp), 64'd1);
    transact(1'b0, 9'h007, 4'h0, 32'h0, 0, "s4_rd2", got, gp);
    chk("s4_rd2_const", 64'(got), 64'(32'h00AB0001));

    // Response back-pressure.
    transact(1'b0, 9'h005, 4'h0, 32'h0, 5, "s5_stall", got, gp);

    // Reset pulse while the RMW is capturing: read happens, write and response do not.
    wr0 = wr_cnt; rd0 = rd_cnt;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 9'h005;
    bus.req_wmask = 4'b0001; bus.req_wdata = 32'h00000011;
    @(negedge clk0);
    bus.req_valid = 1'b0;
    @(negedge clk0);
    rst0 = 1'b1;
    @(negedge clk0);
    chk("s6_rst_csb", 64'(sram_csb0), 64'd1);
    rst0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk0);
      chk("s6_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    chk("s6_no_write", 64'(wr_cnt - wr0), 64'd0);
    chk("s6_one_read", 64'(rd_cnt - rd0), 64'd1);
    transact(1'b0, 9'h005, 4'h0, 32'h0, 0, "s6_rd", got, gp);
    chk("s6_rdata_const", 64'(got), 64'(32'hDEAD5AEF));
    c0 = csb_low_cnt;
    transact(1'b1, 9'h009, 4'h0, 32'h12345678, 0, "s6_m0", got, gp);
    chk("s6_m0_no_access", 64'(csb_low_cnt - c0), 64'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      logic [3:0]    m;
      int            sel;
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) backdoor_flip(a);
      sel = int'($urandom_range(0, 3));
      m = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
      transact($urandom_range(0, 1) == 1, a, m, $urandom, int'($urandom_range(0, 2)), "rnd", got, gp);
    end

    chk("csb_during_reset", 64'(csb_rst_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
